// File: rtl/comb_func4_unit.sv
// comb_func4_unit: registered evaluator of F(A,B,C,D) with self-sweep truth-table capture.
// Define COMB_XCHECK_EN to cross-check the case lookup against gate-level and expression forms.
module comb_func4_unit #(
    parameter int SWEEP_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        sweep_start,
    output logic        y,
    output logic        y_valid,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic [15:0] tt,
    output logic        xchk_err
);
    logic [3:0] idx, code;
    logic       eval, f_case, xchk_hit;

    assign code = sweep_busy ? idx : {a, b, c, d};
    assign eval = sweep_busy | in_valid;

    always_comb begin
        case (code)
            4'd1, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14: f_case = 1'b1;
            default: f_case = 1'b0;
        endcase
    end

`ifdef COMB_XCHECK_EN
    logic f_expr, f_gate, na, nb, nc, nd, p0, p1, p2;
    assign f_expr = (code[3] & ~code[2]) | (code[2] & code[1] & ~code[0]) | (~code[3] & ~code[1] & code[0]);
    not g_na (na, code[3]);
    not g_nb (nb, code[2]);
    not g_nc (nc, code[1]);
    not g_nd (nd, code[0]);
    and g_p0 (p0, code[3], nb);
    and g_p1 (p1, code[2], code[1], nd);
    and g_p2 (p2, na, nc, code[0]);
    or  g_f  (f_gate, p0, p1, p2);
    assign xchk_hit = eval & ((f_gate ^ f_case) | (f_expr ^ f_case));
`else
    assign xchk_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            y          <= 1'b0;
            y_valid    <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            tt         <= 16'h0000;
            xchk_err   <= 1'b0;
            idx        <= 4'd0;
        end else begin
            y_valid    <= eval;
            sweep_done <= 1'b0;
            if (eval) y <= f_case;
            if (xchk_hit) xchk_err <= 1'b1;
            if (sweep_busy) begin
                tt[idx] <= f_case;
                if (idx == 4'(SWEEP_LEN - 1)) begin
                    sweep_busy <= 1'b0;
                    sweep_done <= 1'b1;
                    idx        <= 4'd0;
                end else begin
                    idx <= idx + 4'd1;
                end
            end else if (sweep_start) begin
                sweep_busy <= 1'b1;
                idx        <= 4'd0;
                tt         <= 16'h0000;
            end
        end
    end
endmodule

// File: tb/tb_comb_func4_unit.sv
// tb_comb_func4_unit: directed vectors with a y scoreboard drained by a y_valid monitor,
// plus a second instance with SWEEP_LEN=4 for the short-sweep case.
module tb_comb_func4_unit;
    logic        clk = 1'b0;
    logic        rst, in_valid, a, b, c, d, sweep_start;
    logic        y, y_valid, sweep_busy, sweep_done, xchk_err;
    logic [15:0] tt;
    logic        s_start;
    logic        s_y, s_y_valid, s_busy, s_done, s_xchk;
    logic [15:0] s_tt;
    logic [15:0] full_tt = 16'h4F62;
    logic        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    comb_func4_unit #(.SWEEP_LEN(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
        .sweep_start(sweep_start), .y(y), .y_valid(y_valid), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .tt(tt), .xchk_err(xchk_err)
    );

    comb_func4_unit #(.SWEEP_LEN(4)) u_short (
        .clk(clk), .rst(rst), .in_valid(1'b0), .a(1'b0), .b(1'b0), .c(1'b0), .d(1'b0),
        .sweep_start(s_start), .y(s_y), .y_valid(s_y_valid), .sweep_busy(s_busy),
        .sweep_done(s_done), .tt(s_tt), .xchk_err(s_xchk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (y_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL y_valid with nothing expected: y=%b", y);
            end else begin
                check("y", {15'd0, y}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_sweep(input bit inject);
        int  busy_cnt;
        bit  got;
        busy_cnt = 0;
        got = 0;
        sweep_start = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back(full_tt[k]);
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sweep_busy) busy_cnt++;
            if (sweep_done) begin
                got = 1;
                break;
            end
            if (inject) begin
                in_valid    = (i == 5);
                sweep_start = (i == 5);
                {a, b, c, d} = 4'b1000;
            end
            tick();
        end
        in_valid = 1'b0;
        sweep_start = 1'b0;
        check("sweep_done seen", {15'd0, got}, 16'd1);
        check("busy cycles", 16'(busy_cnt), 16'd16);
        check("tt after sweep", tt, 16'h4F62);
        tick();
        check("done one cycle", {15'd0, sweep_done}, 16'd0);
        check("busy after done", {15'd0, sweep_busy}, 16'd0);
        check("tt holds", tt, 16'h4F62);
    endtask

    initial begin
        int s_cnt;
        bit s_got;
        logic [3:0] codes[6] = '{4'b0001, 4'b0111, 4'b1010, 4'b1110, 4'b1111, 4'b1010};
        logic       exps[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rst = 1'b1; in_valid = 1'b1; sweep_start = 1'b1; s_start = 1'b1;
        {a, b, c, d} = 4'b1111;
        tick();
        tick();
        check("reset y", {15'd0, y}, 16'd0);
        check("reset y_valid", {15'd0, y_valid}, 16'd0);
        check("reset tt", tt, 16'h0000);
        check("reset busy", {15'd0, sweep_busy}, 16'd0);
        check("reset done", {15'd0, sweep_done}, 16'd0);
        check("reset xchk", {15'd0, xchk_err}, 16'd0);
        rst = 1'b0; in_valid = 1'b0; sweep_start = 1'b0; s_start = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            {a, b, c, d} = codes[i];
            exp_q.push_back(exps[i]);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("idle y_valid", {15'd0, y_valid}, 16'd0);
        check("idle y holds", {15'd0, y}, 16'd1);
        check("singles drained", 16'(exp_q.size()), 16'd0);

        run_sweep(0);
        tick();
        run_sweep(1);
        tick();

        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 7; k++) exp_q.push_back(full_tt[k]);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset busy", {15'd0, sweep_busy}, 16'd0);
        check("midreset tt", tt, 16'h0000);
        check("midreset done", {15'd0, sweep_done}, 16'd0);
        check("midreset y_valid", {15'd0, y_valid}, 16'd0);
        tick();
        check("no done after reset", {15'd0, sweep_done}, 16'd0);
        check("midreset drained", 16'(exp_q.size()), 16'd0);
        run_sweep(0);

        s_cnt = 0;
        s_got = 0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_busy) s_cnt++;
            if (s_done) begin
                s_got = 1;
                break;
            end
            tick();
        end
        check("short done seen", {15'd0, s_got}, 16'd1);
        check("short busy cycles", 16'(s_cnt), 16'd4);
        check("short tt", s_tt, 16'h0002);
        check("short xchk", {15'd0, s_xchk}, 16'd0);
        check("short last y", {15'd0, s_y}, 16'd0);
        check("main xchk", {15'd0, xchk_err}, 16'd0);
        tick();
        tick();
        check("final drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
